// File: rtl/cx_mem_arbiter.sv
// Round-robin merge of NUM_REQS DMA request channels into one registered request port, with per-requester in-flight limits.
// Latency: 1 cycle from s_valid&s_ready to m_valid; one request per cycle sustained.
// Backpressure: output register refills only when empty or draining (m_ready); s_ready follows the grant combinationally.
module cx_mem_arbiter #(
    parameter int NUM_REQS      = 2,
    parameter int DATA_WIDTH    = 64,
    parameter int ID_WIDTH      = 4,
    parameter int MAX_IN_FLIGHT = 2,
    localparam int IDX_W        = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [NUM_REQS-1:0]            s_valid,
    output logic [NUM_REQS-1:0]            s_ready,
    input  logic [NUM_REQS*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_REQS*ID_WIDTH-1:0]   s_id,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [DATA_WIDTH-1:0]          m_data,
    output logic [IDX_W+ID_WIDTH-1:0]      m_id,
    input  logic                           i_done_valid,
    input  logic [IDX_W-1:0]               i_done_idx,
    output logic                           o_err
);

    localparam int CNT_W = $clog2(MAX_IN_FLIGHT + 1);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      last_grant, grant_idx;
    logic [NUM_REQS-1:0]   eligible, grant, done_hit, dec;
    logic [CNT_W-1:0]      cnt [NUM_REQS];
    logic                  can_grant, any_grant, err_set;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [ID_WIDTH-1:0]   sel_id;

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            eligible[i] = s_valid[i] && (cnt[i] < CNT_W'(MAX_IN_FLIGHT));
        end
    end

    // Rotating priority search starting just after the previous winner.
    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        sel_data  = '0;
        sel_id    = '0;
        can_grant = (state == EMPTY) || m_ready;
        for (int k = 0; k < NUM_REQS; k++) begin
            j = int'(last_grant) + 1 + k;
            if (j >= NUM_REQS) begin
                j = j - NUM_REQS;
            end
            if (!any_grant && eligible[j]) begin
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
                any_grant = 1'b1;
                sel_data  = s_data[j*DATA_WIDTH +: DATA_WIDTH];
                sel_id    = s_id[j*ID_WIDTH +: ID_WIDTH];
            end
        end
        if (!can_grant || !i_rst_n) begin
            grant     = '0;
            any_grant = 1'b0;
        end
    end

    assign s_ready = grant;
    assign m_valid = (state == FULL);

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (any_grant) state_nxt = FULL;
            FULL:    if (m_ready && !any_grant) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Completions for idle or nonexistent requesters are dropped and flagged.
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            done_hit[i] = i_done_valid && (i_done_idx == IDX_W'(i));
            dec[i]      = done_hit[i] && (cnt[i] != '0);
        end
        err_set = i_done_valid && ((done_hit == '0) || ((done_hit & ~dec) != '0));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= EMPTY;
            m_data     <= '0;
            m_id       <= '0;
            last_grant <= IDX_W'(NUM_REQS - 1);
            o_err      <= 1'b0;
        end else begin
            state <= state_nxt;
            o_err <= o_err | err_set;
            if (any_grant) begin
                m_data     <= sel_data;
                m_id       <= {grant_idx, sel_id};
                last_grant <= grant_idx;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                case ({grant[i], dec[i]})
                    2'b10:   cnt[i] <= cnt[i] + 1'b1;
                    2'b01:   cnt[i] <= cnt[i] - 1'b1;
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cx_mem_arbiter.sv
// Scenario bench for cx_mem_arbiter (2 requesters, 2 in flight each); payload ordering checked by a queue scoreboard.
module tb_cx_mem_arbiter;

    logic         clk;
    logic         rst_n;
    logic [1:0]   s_valid;
    logic [1:0]   s_ready;
    logic [127:0] s_data;
    logic [7:0]   s_id;
    logic         m_valid;
    logic         m_ready;
    logic [63:0]  m_data;
    logic [4:0]   m_id;
    logic         done_valid;
    logic [0:0]   done_idx;
    logic         o_err;

    int n_total = 0;
    int n_pass  = 0;
    logic [68:0] exp_q[$];
    logic [68:0] exp_item;

    cx_mem_arbiter #(
        .NUM_REQS(2), .DATA_WIDTH(64), .ID_WIDTH(4), .MAX_IN_FLIGHT(2)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_id(s_id),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_id(m_id),
        .i_done_valid(done_valid), .i_done_idx(done_idx), .o_err(o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: pop on output handshake, push on input handshake.
    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_underflow: got id=%h data=%h, expected no output", m_id, m_data);
            end else begin
                exp_item = exp_q.pop_front();
                if ({m_id, m_data} !== exp_item)
                    $display("FAIL sb_payload: got %h want %h", {m_id, m_data}, exp_item);
                else
                    n_pass++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (s_valid[i] && s_ready[i])
                exp_q.push_back({1'(i), s_id[i*4 +: 4], s_data[i*64 +: 64]});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        s_data = {$urandom, $urandom, $urandom, $urandom};
        s_id   = 8'($urandom);
    endtask

    task automatic drain();
        s_valid    = 2'b00;
        m_ready    = 1'b1;
        done_valid = 1'b0;
        repeat (3) step();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n      = 1'b0;
        s_valid    = 2'b00;
        m_ready    = 1'b0;
        done_valid = 1'b0;
        #3;
        exp_q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic chk_ready(input string name, input logic [1:0] want);
        n_total++;
        if (s_ready !== want) $display("FAIL %s: s_ready got %b want %b", name, s_ready, want);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 2'b11; m_ready = 1'b1; done_valid = 1'b0; done_idx = 1'b0;
        s_data = '1; s_id = '1;
        #12;
        n_total++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b want 0", m_valid); else n_pass++;
        n_total++; if (m_data !== 64'd0) $display("FAIL rst_m_data: got %h want 0", m_data); else n_pass++;
        n_total++; if (m_id !== 5'd0) $display("FAIL rst_m_id: got %h want 0", m_id); else n_pass++;
        n_total++; if (o_err !== 1'b0) $display("FAIL rst_o_err: got %b want 0", o_err); else n_pass++;
        chk_ready("rst_s_ready", 2'b00);
        s_valid = 2'b00;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        step(); s_valid = 2'b11; m_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk_ready($sformatf("rr_grant_%0d", c), (c < 4) ? 2'(1 << (c % 2)) : 2'b00);
            if (c > 0) begin
                n_total++;
                if (m_valid !== 1'b1 || m_id[4] !== 1'((c - 1) % 2))
                    $display("FAIL rr_m_id_%0d: got vld=%b idx=%b want vld=1 idx=%0d", c, m_valid, m_id[4], (c - 1) % 2);
                else n_pass++;
            end
            step();
        end
        drain();
        do_reset();
    endtask

    task automatic test_backpressure();
        logic [63:0] d0;
        step(); s_valid = 2'b10; m_ready = 1'b0;
        @(negedge clk);
        chk_ready("bp_first_accept", 2'b10);
        d0 = s_data[127:64];
        step();
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_total++;
            if (m_valid !== 1'b1 || m_data !== d0)
                $display("FAIL bp_hold_%0d: got vld=%b data=%h want vld=1 data=%h", c, m_valid, m_data, d0);
            else n_pass++;
            chk_ready($sformatf("bp_stall_%0d", c), 2'b00);
            step();
        end
        m_ready = 1'b1;
        @(negedge clk);
        chk_ready("bp_refill", 2'b10);
        step();
        @(negedge clk);
        chk_ready("bp_limit", 2'b00);
        n_total++; if (m_valid !== 1'b1) $display("FAIL bp_refill_vld: got %b want 1", m_valid); else n_pass++;
        drain();
        do_reset();
    endtask

    task automatic test_in_flight();
        step(); s_valid = 2'b01; m_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk_ready($sformatf("if_grant_%0d", c), (c < 2) ? 2'b01 : 2'b00);
            step();
        end
        done_valid = 1'b1; done_idx = 1'b0;
        @(negedge clk);
        chk_ready("if_no_comb_free", 2'b00);
        step(); done_valid = 1'b0;
        @(negedge clk);
        chk_ready("if_freed", 2'b01);
        step();
        @(negedge clk);
        chk_ready("if_refull", 2'b00);
        n_total++; if (o_err !== 1'b0) $display("FAIL if_o_err: got %b want 0", o_err); else n_pass++;
        drain();
        do_reset();
    endtask

    task automatic test_same_cycle();
        step(); s_valid = 2'b01; m_ready = 1'b1;
        @(negedge clk);
        chk_ready("sc_first", 2'b01);
        step(); done_valid = 1'b1; done_idx = 1'b0;
        @(negedge clk);
        chk_ready("sc_grant_and_done", 2'b01);
        step(); done_valid = 1'b0;
        @(negedge clk);
        chk_ready("sc_cnt_held_1", 2'b01);
        step();
        @(negedge clk);
        chk_ready("sc_cnt_full", 2'b00);
        n_total++; if (o_err !== 1'b0) $display("FAIL sc_o_err: got %b want 0", o_err); else n_pass++;
        drain();
        do_reset();
    endtask

    task automatic test_err();
        step(); done_valid = 1'b1; done_idx = 1'b1;
        @(negedge clk);
        n_total++; if (o_err !== 1'b0) $display("FAIL err_before_edge: got %b want 0", o_err); else n_pass++;
        step(); done_valid = 1'b0; s_valid = 2'b10; m_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk_ready($sformatf("err_cnt1_grant_%0d", c), (c < 2) ? 2'b10 : 2'b00);
            n_total++; if (o_err !== 1'b1) $display("FAIL err_sticky_%0d: got %b want 1", c, o_err); else n_pass++;
            step();
        end
        drain();
    endtask

    task automatic test_reset_mid();
        step(); s_valid = 2'b01; m_ready = 1'b0;
        @(negedge clk);
        chk_ready("rm_accept", 2'b01);
        step();
        @(negedge clk);
        n_total++; if (m_valid !== 1'b1) $display("FAIL rm_full: got %b want 1", m_valid); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (m_valid !== 1'b0) $display("FAIL rm_async_vld: got %b want 0", m_valid); else n_pass++;
        n_total++; if (m_data !== 64'd0 || m_id !== 5'd0) $display("FAIL rm_async_dat: got %h/%h want 0/0", m_id, m_data); else n_pass++;
        n_total++; if (o_err !== 1'b0) $display("FAIL rm_async_err: got %b want 0", o_err); else n_pass++;
        chk_ready("rm_ready_in_reset", 2'b00);
        exp_q.delete();
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1; s_valid = 2'b11;
        #1;
        chk_ready("rm_first_after_release", 2'b01);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk_ready($sformatf("rm_seq_%0d", c), (c < 4) ? 2'(1 << (c % 2)) : 2'b00);
            step();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_in_flight();
        test_same_cycle();
        test_err();
        test_reset_mid();
        n_total++;
        if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
